// File: rtl/serial_borrow_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_borrow_subtractor
//  Description : Bit-serial ripple-borrow subtractor. Computes
//                {bout, diff} = a - b - bin one bit per clock, LSB first,
//                with one shared full-subtractor cell. Operands enter on a
//                valid/ready channel; the result leaves on a valid/ready
//                channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_borrow_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic [WIDTH:0]   final_diff,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Wide enough to count up to 31 for the largest legal WIDTH.
    localparam int              CNT_W  = 6;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q;      // minuend shift register
    logic [WIDTH-1:0] sb_q;      // subtrahend shift register
    logic [WIDTH-1:0] sd_q;      // difference shift register, fills from MSB
    logic             br_q;      // running borrow
    logic [CNT_W-1:0] cnt_q;     // index of the bit being processed
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             w_accept;
    logic             w_release;
    logic             w_last;
    logic             w_x, w_y;
    logic             w_d_bit;
    logic             w_br_next;
    logic [WIDTH-1:0] w_sd_next;

    // Single full-subtractor cell working on the current LSBs.
    assign w_x       = sa_q[0];
    assign w_y       = sb_q[0];
    assign w_d_bit   = w_x ^ w_y ^ br_q;
    assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & br_q);
    // Shift right and drop the new bit into the MSB; written as shift/or so
    // the expression stays legal when WIDTH is 1.
    assign w_sd_next = (sd_q >> 1) | (WIDTH'(w_d_bit) << (WIDTH - 1));

    assign w_accept  = in_valid  & in_ready;
    assign w_release = out_valid & out_ready;
    assign w_last    = (state_q == S_RUN) && (cnt_q == C_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last bit,
    // DONE -> IDLE on the output handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept)  state_d = S_RUN;
            S_RUN:   if (w_last)    state_d = S_DONE;
            S_DONE:  if (w_release) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded straight from the state.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    // Datapath: latch operands on accept, shift one bit per RUN cycle, and
    // publish the result only on the final RUN edge so no partial value leaks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q   <= '0;
            sb_q   <= '0;
            sd_q   <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (w_accept) begin
            sa_q  <= a;
            sb_q  <= b;
            br_q  <= bin;
            sd_q  <= '0;
            cnt_q <= '0;
        end else if (state_q == S_RUN) begin
            sa_q  <= sa_q >> 1;
            sb_q  <= sb_q >> 1;
            br_q  <= w_br_next;
            sd_q  <= w_sd_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (w_last) begin
                diff_q <= w_sd_next;
                bout_q <= w_br_next;
            end
        end
    end

    assign diff       = diff_q;
    assign bout       = bout_q;
    assign final_diff = {bout_q, diff_q};

endmodule
`default_nettype wire

// File: tb/tb_serial_borrow_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_borrow_subtractor
//  Description : Self-checking bench for serial_borrow_subtractor. Drives a
//                WIDTH=4 and a WIDTH=8 instance through shared stimulus
//                signals selected by sel; directed table, corner sequences
//                and randomised operations checked against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_borrow_subtractor;

    logic clk;
    logic rst_n;
    logic sel;                 // 0 selects the WIDTH=4 DUT, 1 the WIDTH=8 DUT

    logic [7:0] drv_a, drv_b;
    logic       drv_bin, drv_valid, drv_oready;

    // WIDTH=4 instance signals
    logic       iv4, ir4, ov4, or4, bo4, busy4;
    logic [3:0] d4;
    logic [4:0] f4;
    // WIDTH=8 instance signals
    logic       iv8, ir8, ov8, or8, bo8, busy8;
    logic [7:0] d8;
    logic [8:0] f8;

    // Muxed view of the selected DUT
    logic       m_in_ready, m_out_valid, m_bout, m_busy;
    logic [7:0] m_diff;
    logic [8:0] m_final;

    int nvec  = 0;
    int nfail = 0;

    assign iv4 = drv_valid  & ~sel;
    assign or4 = drv_oready & ~sel;
    assign iv8 = drv_valid  &  sel;
    assign or8 = drv_oready &  sel;

    assign m_in_ready  = sel ? ir8   : ir4;
    assign m_out_valid = sel ? ov8   : ov4;
    assign m_bout      = sel ? bo8   : bo4;
    assign m_busy      = sel ? busy8 : busy4;
    assign m_diff      = sel ? d8    : {4'd0, d4};
    assign m_final     = sel ? f8    : {4'd0, f4};

    serial_borrow_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4),
        .a(drv_a[3:0]), .b(drv_b[3:0]), .bin(drv_bin),
        .out_valid(ov4), .out_ready(or4),
        .diff(d4), .bout(bo4), .final_diff(f4), .busy(busy4)
    );

    serial_borrow_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(drv_a), .b(drv_b), .bin(drv_bin),
        .out_valid(ov8), .out_ready(or8),
        .diff(d8), .bout(bo8), .final_diff(f8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] ed;
        logic       eb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int cyc = 0;
        while (!m_in_ready && cyc < 40) begin
            tick();
            cyc++;
        end
        if (!m_in_ready) check({name, " in_ready timeout"}, 32'(m_in_ready), 32'd1);
    endtask

    // Accept one operation, measure latency, check the result, then release it.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic bin, input logic [7:0] ed, input logic eb);
        int cyc = 0;
        int lat = sel ? 8 : 4;
        wait_ready(name);
        drv_a = a; drv_b = b; drv_bin = bin; drv_valid = 1'b1;
        tick();
        drv_valid = 1'b0;
        while (!m_out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'(lat));
        check({name, " diff"}, 32'(m_diff), 32'(ed));
        check({name, " bout"}, 32'(m_bout), 32'(eb));
        check({name, " final_diff"}, 32'(m_final), sel ? 32'({eb, ed}) : 32'({eb, ed[3:0]}));
        drv_oready = 1'b1;
        tick();
        drv_oready = 1'b0;
        check({name, " out_valid drop"}, 32'(m_out_valid), 32'd0);
        check({name, " in_ready back"}, 32'(m_in_ready), 32'd1);
    endtask

    // Back-to-back random operations with random out_ready, checked against a model.
    task automatic rand_ops(input int n);
        int w = sel ? 8 : 4;
        int mx = (1 << w) - 1;
        for (int i = 0; i < n; i++) begin
            int ia = $urandom_range(0, mx);
            int ib = $urandom_range(0, mx);
            int ic = $urandom_range(0, 1);
            int cyc = 0;
            int expv = (ia - ib - ic) & ((1 << (w + 1)) - 1);
            logic done = 1'b0;
            wait_ready("rand");
            drv_a = 8'(ia); drv_b = 8'(ib); drv_bin = ic[0]; drv_valid = 1'b1;
            tick();
            drv_valid = 1'b0;
            while (!m_out_valid && cyc < 40) begin
                drv_oready = 1'($urandom_range(0, 1));
                tick();
                cyc++;
            end
            check("rand final_diff", 32'(m_final), 32'(expv));
            cyc = 0;
            while (!done && cyc < 60) begin
                drv_oready = 1'($urandom_range(0, 1));
                done = drv_oready;
                tick();
                cyc++;
            end
            drv_oready = 1'b0;
        end
    endtask

    initial begin
        vec_t tbl4[10];
        vec_t tbl8[3];

        tbl4[0] = '{8'd9,  8'd3,  1'b0, 8'h6, 1'b0};
        tbl4[1] = '{8'd3,  8'd9,  1'b0, 8'hA, 1'b1};
        tbl4[2] = '{8'd0,  8'd0,  1'b1, 8'hF, 1'b1};
        tbl4[3] = '{8'd15, 8'd15, 1'b0, 8'h0, 1'b0};
        tbl4[4] = '{8'd15, 8'd0,  1'b1, 8'hE, 1'b0};
        tbl4[5] = '{8'd0,  8'd15, 1'b0, 8'h1, 1'b1};
        tbl4[6] = '{8'd8,  8'd8,  1'b1, 8'hF, 1'b1};
        tbl4[7] = '{8'd5,  8'd4,  1'b1, 8'h0, 1'b0};
        tbl4[8] = '{8'd10, 8'd3,  1'b1, 8'h6, 1'b0};
        tbl4[9] = '{8'd15, 8'd0,  1'b0, 8'hF, 1'b0};

        tbl8[0] = '{8'd200, 8'd201, 1'b0, 8'hFF, 1'b1};
        tbl8[1] = '{8'd0,   8'd0,   1'b1, 8'hFF, 1'b1};
        tbl8[2] = '{8'd170, 8'd85,  1'b1, 8'h54, 1'b0};

        sel = 1'b0;
        drv_a = '0; drv_b = '0; drv_bin = 1'b0; drv_valid = 1'b0; drv_oready = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();

        // Reset state
        check("reset out_valid",  32'(m_out_valid), 32'd0);
        check("reset in_ready",   32'(m_in_ready),  32'd1);
        check("reset busy",       32'(m_busy),      32'd0);
        check("reset diff",       32'(m_diff),      32'd0);
        check("reset bout",       32'(m_bout),      32'd0);
        check("reset final_diff", 32'(m_final),     32'd0);
        rst_n = 1'b1;
        tick();

        // Directed table, WIDTH=4
        for (int i = 0; i < 10; i++)
            run_op($sformatf("w4 vec%0d", i), tbl4[i].a, tbl4[i].b, tbl4[i].bin, tbl4[i].ed, tbl4[i].eb);

        // Back-pressure: result held for 10 cycles while a competing operand is offered
        begin
            int cyc = 0;
            drv_a = 8'd12; drv_b = 8'd5; drv_bin = 1'b0; drv_valid = 1'b1;
            tick();
            drv_a = 8'd1; drv_b = 8'd2;
            while (!m_out_valid && cyc < 40) begin
                tick();
                cyc++;
            end
            for (int i = 0; i < 10; i++) begin
                check("bp out_valid", 32'(m_out_valid), 32'd1);
                check("bp in_ready",  32'(m_in_ready),  32'd0);
                check("bp final_diff", 32'(m_final),    32'h07);
                tick();
            end
            drv_oready = 1'b1;
            tick();
            drv_oready = 1'b0;
            drv_valid  = 1'b0;
            check("bp release out_valid", 32'(m_out_valid), 32'd0);
            check("bp release in_ready",  32'(m_in_ready),  32'd1);
            check("bp release busy",      32'(m_busy),      32'd0);
            check("bp diff kept",         32'(m_diff),      32'h7);
        end

        // Reset in the second RUN cycle
        begin
            int seen = 0;
            drv_a = 8'd9; drv_b = 8'd3; drv_bin = 1'b0; drv_valid = 1'b1;
            tick();
            drv_valid = 1'b0;
            tick();
            rst_n = 1'b0;
            #1;
            check("abort in_ready",   32'(m_in_ready),  32'd1);
            check("abort busy",       32'(m_busy),      32'd0);
            check("abort out_valid",  32'(m_out_valid), 32'd0);
            check("abort final_diff", 32'(m_final),     32'd0);
            repeat (2) tick();
            rst_n = 1'b1;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (m_out_valid) seen++;
            end
            check("abort no out_valid", 32'(seen), 32'd0);
            run_op("after abort", 8'd7, 8'd2, 1'b0, 8'h5, 1'b0);
        end

        rand_ops(500);

        // WIDTH=8 instance
        sel = 1'b1;
        tick();
        for (int i = 0; i < 3; i++)
            run_op($sformatf("w8 vec%0d", i), tbl8[i].a, tbl8[i].b, tbl8[i].bin, tbl8[i].ed, tbl8[i].eb);
        rand_ops(500);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        nfail++;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
